// File: rtl/sc_micro_sequencer.sv
// sc_micro_sequencer
//   Microprogram sequencer sitting behind the instruction register. Every
//   falling edge of SC_MicroSeq_CLOCK_50 it picks the next control-store
//   address from: increment, unconditional jump, flag/BIT13-conditional jump,
//   or opcode decode. Undefined opcodes are redirected to TRAP_ADDR and latch
//   a sticky illegal-opcode flag.
//
//   Ports
//     SC_MicroSeq_CLOCK_50      in   system clock, state changes on falling edge
//     SC_MicroSeq_Reset_InHigh  in   synchronous reset, active-high, beats Hold
//     SC_MicroSeq_Hold_InHigh   in   freeze all state (memory wait)
//     SC_MicroSeq_COND          in   microword branch condition
//     SC_MicroSeq_JUMPADDR      in   microword jump target
//     SC_MicroSeq_OP/OP2/OP3    in   IR[31:30] / IR[24:22] / IR[24:19]
//     SC_MicroSeq_BIT13         in   IR[13]
//     SC_MicroSeq_PSR_NZVC      in   PSR flags {N,Z,V,C}
//     SC_MicroSeq_CSAI_Out      out  current control-store address
//     SC_MicroSeq_Taken_Out     out  last update left the sequential path
//     SC_MicroSeq_IllegalOp_Out out  sticky illegal-opcode flag
//
//   Next-address selection (COND)
//     cond | meaning
//     000  | CSAI+1
//     001  | N     ? JUMPADDR : CSAI+1
//     010  | Z     ? JUMPADDR : CSAI+1
//     011  | V     ? JUMPADDR : CSAI+1
//     100  | C     ? JUMPADDR : CSAI+1
//     101  | BIT13 ? JUMPADDR : CSAI+1
//     110  | JUMPADDR
//     111  | opcode decode (or TRAP_ADDR for an illegal opcode)

module sc_micro_sequencer #(
  parameter int                   ADDRWIDTH  = 11,
  parameter logic [ADDRWIDTH-1:0] RESET_ADDR = 11'h000,
  parameter logic [ADDRWIDTH-1:0] TRAP_ADDR  = 11'h7FC
) (
  input  logic                 SC_MicroSeq_CLOCK_50,
  input  logic                 SC_MicroSeq_Reset_InHigh,
  input  logic                 SC_MicroSeq_Hold_InHigh,
  input  logic [2:0]           SC_MicroSeq_COND,
  input  logic [ADDRWIDTH-1:0] SC_MicroSeq_JUMPADDR,
  input  logic [1:0]           SC_MicroSeq_OP,
  input  logic [2:0]           SC_MicroSeq_OP2,
  input  logic [5:0]           SC_MicroSeq_OP3,
  input  logic                 SC_MicroSeq_BIT13,
  input  logic [3:0]           SC_MicroSeq_PSR_NZVC,
  output logic [ADDRWIDTH-1:0] SC_MicroSeq_CSAI_Out,
  output logic                 SC_MicroSeq_Taken_Out,
  output logic                 SC_MicroSeq_IllegalOp_Out
);

  typedef enum logic [2:0] {
    CondInc   = 3'b000,
    CondN     = 3'b001,
    CondZ     = 3'b010,
    CondV     = 3'b011,
    CondC     = 3'b100,
    CondBit13 = 3'b101,
    CondJump  = 3'b110,
    CondDec   = 3'b111
  } condT;

  condT                 condSel;
  logic [ADDRWIDTH-1:0] seqAddr;
  logic [5:0]           decodeField;
  logic [10:0]          decodeAddr;
  logic                 illegalOp;
  logic                 branchTest;
  logic [ADDRWIDTH-1:0] nextAddr;
  logic                 nextTaken;

  assign condSel = condT'(SC_MicroSeq_COND);

  // Natural wrap of the adder gives the modulo-2^ADDRWIDTH increment.
  assign seqAddr = SC_MicroSeq_CSAI_Out + 1'b1;

  // Only the two format-2 opcodes (OP2 = 010, 100) are defined for OP=00.
  assign illegalOp = (SC_MicroSeq_OP == 2'b00) &&
                     (SC_MicroSeq_OP2 != 3'b010) && (SC_MicroSeq_OP2 != 3'b100);

  always_comb begin
    decodeField = 6'b000000;
    case (SC_MicroSeq_OP)
      2'b00:   decodeField = {SC_MicroSeq_OP2, 3'b000};
      2'b01:   decodeField = 6'b000000;
      default: decodeField = SC_MicroSeq_OP3;
    endcase
  end

  // Decode entries live in the upper half of the control store, 4 words apart.
  assign decodeAddr = {1'b1, SC_MicroSeq_OP, decodeField, 2'b00};

  always_comb begin
    branchTest = 1'b0;
    case (condSel)
      CondN:     branchTest = SC_MicroSeq_PSR_NZVC[3];
      CondZ:     branchTest = SC_MicroSeq_PSR_NZVC[2];
      CondV:     branchTest = SC_MicroSeq_PSR_NZVC[1];
      CondC:     branchTest = SC_MicroSeq_PSR_NZVC[0];
      CondBit13: branchTest = SC_MicroSeq_BIT13;
      CondJump:  branchTest = 1'b1;
      default:   branchTest = 1'b0;
    endcase
  end

  always_comb begin
    nextAddr  = seqAddr;
    nextTaken = 1'b0;
    if (condSel == CondDec) begin
      nextAddr  = illegalOp ? TRAP_ADDR : ADDRWIDTH'(decodeAddr);
      nextTaken = 1'b1;
    end else if (branchTest) begin
      nextAddr  = SC_MicroSeq_JUMPADDR;
      nextTaken = 1'b1;
    end
  end

  always_ff @(negedge SC_MicroSeq_CLOCK_50) begin
    if (SC_MicroSeq_Reset_InHigh) begin
      SC_MicroSeq_CSAI_Out      <= RESET_ADDR;
      SC_MicroSeq_Taken_Out     <= 1'b0;
      SC_MicroSeq_IllegalOp_Out <= 1'b0;
    end else if (!SC_MicroSeq_Hold_InHigh) begin
      SC_MicroSeq_CSAI_Out  <= nextAddr;
      SC_MicroSeq_Taken_Out <= nextTaken;
      if ((condSel == CondDec) && illegalOp)
        SC_MicroSeq_IllegalOp_Out <= 1'b1;
    end
  end

endmodule
